// File: rtl/ibex_lsu_resp_unit.sv
// Data-side LSU: one outstanding req/gnt/rvalid transaction, load formatting.
// Optional IBEX_LSU_ERR_ADDR_EN adds lsu_err_addr_o, the last faulting address.
module ibex_lsu_resp_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_req_done_o,
    output logic        busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        rf_we_lsu_o,
    output logic [31:0] rf_wdata_lsu_o
`ifdef IBEX_LSU_ERR_ADDR_EN
    ,
    output logic [31:0] lsu_err_addr_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        MIS_ERR
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        sign_q;
    logic [1:0]  type_q;

    function automatic logic [3:0] be_of(input logic [1:0] ty,
                                         input logic [1:0] off);
        case (ty)
            2'b10:   be_of = 4'b0001 << off;
            2'b01:   be_of = 4'b0011 << off;
            default: be_of = 4'hF;
        endcase
    endfunction

    function automatic logic mis_of(input logic [1:0] ty,
                                    input logic [1:0] off);
        case (ty)
            2'b10:   mis_of = 1'b0;
            2'b01:   mis_of = off[0];
            default: mis_of = (off != 2'b00);
        endcase
    endfunction

    logic        idle_req;
    logic        mis_req;
    logic        bus_req;
    logic        in_rsp;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_we;
    logic [1:0]  cur_type;
    logic [31:0] shifted;
    logic [31:0] fmt;

    // In IDLE the bus sees the live request; afterwards the captured copy.
    always_comb begin
        idle_req  = (state_q == IDLE) & lsu_req_i & ~rst_i;
        mis_req   = mis_of(lsu_type_i, lsu_addr_i[1:0]);
        bus_req   = (idle_req & ~mis_req) | (state_q == WAIT_GNT);
        cur_addr  = (state_q == IDLE) ? lsu_addr_i  : addr_q;
        cur_wdata = (state_q == IDLE) ? lsu_wdata_i : wdata_q;
        cur_we    = (state_q == IDLE) ? lsu_we_i    : we_q;
        cur_type  = (state_q == IDLE) ? lsu_type_i  : type_q;

        data_req_o   = bus_req;
        data_addr_o  = bus_req ? {cur_addr[31:2], 2'b00} : 32'h0;
        data_we_o    = bus_req & cur_we;
        data_be_o    = bus_req ? be_of(cur_type, cur_addr[1:0]) : 4'h0;
        data_wdata_o = bus_req ?
                       cur_wdata << {cur_addr[1:0], 3'b000} : 32'h0;

        lsu_req_done_o = (idle_req & mis_req) | (bus_req & data_gnt_i);
        busy_o         = (state_q != IDLE);
    end

    always_comb begin
        in_rsp  = (state_q == WAIT_RVALID) & data_rvalid_i;
        shifted = data_rdata_i >> {addr_q[1:0], 3'b000};
        case (type_q)
            2'b10:   fmt = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   fmt = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: fmt = shifted;
        endcase

        lsu_resp_valid_o = in_rsp | (state_q == MIS_ERR);
        lsu_resp_err_o   = (in_rsp & data_err_i) | (state_q == MIS_ERR);
        rf_we_lsu_o      = in_rsp & ~we_q & ~data_err_i;
        rf_wdata_lsu_o   = rf_we_lsu_o ? fmt : 32'h0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            type_q  <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        addr_q  <= lsu_addr_i;
                        wdata_q <= lsu_wdata_i;
                        we_q    <= lsu_we_i;
                        sign_q  <= lsu_sign_ext_i;
                        type_q  <= lsu_type_i;
                        if (mis_req)         state_q <= MIS_ERR;
                        else if (data_gnt_i) state_q <= WAIT_RVALID;
                        else                 state_q <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) state_q <= IDLE;
                end
                MIS_ERR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IBEX_LSU_ERR_ADDR_EN
    logic [31:0] err_addr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_addr_q <= 32'h0;
        end else if (lsu_resp_valid_o & lsu_resp_err_o) begin
            err_addr_q <= addr_q;
        end
    end

    assign lsu_err_addr_o = err_addr_q;
`endif

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
// Bench for ibex_lsu_resp_unit: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ibex_lsu_resp_unit;

    logic        clk;
    logic        rst;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_type;
    logic        lsu_sign;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        req_done;
    logic        busy;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic        data_err;
    logic [31:0] data_rdata;
    logic        resp_valid;
    logic        resp_err;
    logic        rf_we;
    logic [31:0] rf_wdata;
`ifdef IBEX_LSU_ERR_ADDR_EN
    logic [31:0] err_addr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ibex_lsu_resp_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .lsu_req_i       (lsu_req),
        .lsu_we_i        (lsu_we),
        .lsu_type_i      (lsu_type),
        .lsu_sign_ext_i  (lsu_sign),
        .lsu_addr_i      (lsu_addr),
        .lsu_wdata_i     (lsu_wdata),
        .lsu_req_done_o  (req_done),
        .busy_o          (busy),
        .data_req_o      (data_req),
        .data_gnt_i      (data_gnt),
        .data_addr_o     (data_addr),
        .data_we_o       (data_we),
        .data_be_o       (data_be),
        .data_wdata_o    (data_wdata),
        .data_rvalid_i   (data_rvalid),
        .data_err_i      (data_err),
        .data_rdata_i    (data_rdata),
        .lsu_resp_valid_o(resp_valid),
        .lsu_resp_err_o  (resp_err),
        .rf_we_lsu_o     (rf_we),
        .rf_wdata_lsu_o  (rf_wdata)
`ifdef IBEX_LSU_ERR_ADDR_EN
        ,
        .lsu_err_addr_o  (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        granted;
        logic        mis;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  ty;
        logic        sg;
        logic [31:0] wd;
        logic [31:0] err_addr;
    } model_t;

    typedef struct packed {
        logic        done;
        logic        busy;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rv;
        logic        err;
        logic        rfwe;
        logic [31:0] rfwd;
    } exp_t;

    model_t m;

    function automatic int sz(logic [1:0] ty);
        if (ty == 2'b10) return 1;
        if (ty == 2'b01) return 2;
        return 4;
    endfunction

    function automatic exp_t bus_view(exp_t e, logic [31:0] a,
                                      logic [1:0] ty, logic we,
                                      logic [31:0] wd);
        int o;
        int n;
        logic [63:0] p;
        o = int'(a % 4);
        n = sz(ty);
        e.req  = 1'b1;
        e.we   = we;
        e.addr = a - (a % 4);
        for (int i = 0; i < 4; i++)
            e.be[i] = (i >= o) && (i < o + n);
        p = {32'h0, wd} * (64'd1 << (8 * o));
        e.wd = p[31:0];
        return e;
    endfunction

    function automatic logic [31:0] load_fmt(logic [31:0] rd,
                                             logic [31:0] a,
                                             logic [1:0] ty, logic sg);
        int o;
        int n;
        logic [31:0] v;
        logic [31:0] mask;
        o = int'(a % 4);
        n = sz(ty);
        v = rd >> (8 * o);
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (sg && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e = '0;
        if (rst) return e;
        e.busy = m.busy;
        if (!m.busy) begin
            if (lsu_req) begin
                if (lsu_addr % sz(lsu_type) == 0) begin
                    e = bus_view(e, lsu_addr, lsu_type, lsu_we, lsu_wdata);
                    e.done = data_gnt;
                end else begin
                    e.done = 1'b1;
                end
            end
        end else if (m.mis) begin
            e.rv  = 1'b1;
            e.err = 1'b1;
        end else if (!m.granted) begin
            e = bus_view(e, m.addr, m.ty, m.we, m.wd);
            e.done = data_gnt;
        end else if (data_rvalid) begin
            e.rv   = 1'b1;
            e.err  = data_err;
            e.rfwe = !m.we && !data_err;
            if (e.rfwe) e.rfwd = load_fmt(data_rdata, m.addr, m.ty, m.sg);
        end
        return e;
    endfunction

    function automatic model_t next_model(model_t s, exp_t e);
        model_t t;
        t = s;
        if (e.rv && e.err) t.err_addr = s.addr;
        if (!s.busy) begin
            if (lsu_req) begin
                t.busy    = 1'b1;
                t.mis     = (lsu_addr % sz(lsu_type) != 0);
                t.granted = e.done && !t.mis;
                t.addr    = lsu_addr;
                t.we      = lsu_we;
                t.ty      = lsu_type;
                t.sg      = lsu_sign;
                t.wd      = lsu_wdata;
            end
        end else if (s.mis) begin
            t.busy = 1'b0;
        end else if (!s.granted) begin
            if (data_gnt) t.granted = 1'b1;
        end else if (data_rvalid) begin
            t.busy = 1'b0;
        end
        return t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= next_model(m, expect_now());
    end

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        e = expect_now();
        cmp("done", 32'(req_done), 32'(e.done));
        cmp("busy", 32'(busy), 32'(e.busy));
        cmp("data_req", 32'(data_req), 32'(e.req));
        cmp("data_we", 32'(data_we), 32'(e.we));
        cmp("data_addr", data_addr, e.addr);
        cmp("data_be", 32'(data_be), 32'(e.be));
        cmp("data_wdata", data_wdata, e.wd);
        cmp("resp_valid", 32'(resp_valid), 32'(e.rv));
        cmp("resp_err", 32'(resp_err), 32'(e.err));
        cmp("rf_we", 32'(rf_we), 32'(e.rfwe));
        cmp("rf_wdata", rf_wdata, e.rfwd);
`ifdef IBEX_LSU_ERR_ADDR_EN
        cmp("err_addr", err_addr, rst ? 32'h0 : m.err_addr);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        lsu_req     = 1'b0;
        lsu_we      = 1'b0;
        lsu_type    = 2'b00;
        lsu_sign    = 1'b0;
        lsu_addr    = 32'h0;
        lsu_wdata   = 32'h0;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_err    = 1'b0;
        data_rdata  = 32'h0;
    endtask

    task automatic issue(logic we, logic [1:0] ty, logic sg,
                         logic [31:0] a, logic [31:0] wd, logic gnt);
        lsu_req   = 1'b1;
        lsu_we    = we;
        lsu_type  = ty;
        lsu_sign  = sg;
        lsu_addr  = a;
        lsu_wdata = wd;
        data_gnt  = gnt;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        #2;
        cmp("rst_busy", 32'(busy), 32'h0);
        cmp("rst_req", 32'(data_req), 32'h0);
        cmp("rst_resp", 32'(resp_valid), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // load byte 0x1003 signed, gnt same cycle, rvalid two cycles later
        tick();
        issue(1'b0, 2'b10, 1'b1, 32'h1003, 32'h0, 1'b1);
        #2;
        cmp("lb_be", 32'(data_be), 32'h8);
        cmp("lb_addr", data_addr, 32'h1000);
        cmp("lb_done", 32'(req_done), 32'h1);
        tick();
        quiet();
        tick();
        tick();
        data_rvalid = 1'b1;
        data_rdata  = 32'h80FF_0000;
        #2;
        cmp("lb_rfwd", rf_wdata, 32'hFFFF_FF80);
        cmp("lb_rfwe", 32'(rf_we), 32'h1);
        cmp("lb_err", 32'(resp_err), 32'h0);
        tick();
        quiet();

        // load half unsigned 0x2002, grant after three waiting cycles
        issue(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #2;
            cmp("lh_req", 32'(data_req), 32'h1);
            cmp("lh_addr", data_addr, 32'h2000);
            cmp("lh_be", 32'(data_be), 32'hC);
            tick();
            lsu_req  = 1'b0;
            lsu_addr = 32'hDEAD_0001;
            lsu_type = 2'b10;
            data_gnt = (c == 2);
        end
        quiet();
        data_rvalid = 1'b1;
        data_rdata  = 32'hBEEF_1234;
        #2;
        cmp("lh_rfwd", rf_wdata, 32'h0000_BEEF);
        tick();
        quiet();

        // store byte 0xA5 at 0x3001
        issue(1'b1, 2'b10, 1'b0, 32'h3001, 32'h0000_00A5, 1'b1);
        #2;
        cmp("sb_wdata", data_wdata, 32'h0000_A500);
        cmp("sb_be", 32'(data_be), 32'h2);
        cmp("sb_we", 32'(data_we), 32'h1);
        tick();
        quiet();
        data_rvalid = 1'b1;
        data_rdata  = 32'h1234_5678;
        #2;
        cmp("sb_rv", 32'(resp_valid), 32'h1);
        cmp("sb_rfwe", 32'(rf_we), 32'h0);
        tick();
        quiet();

        // misaligned word load at 0x4002
        issue(1'b0, 2'b00, 1'b0, 32'h4002, 32'h0, 1'b1);
        #2;
        cmp("mis_req", 32'(data_req), 32'h0);
        cmp("mis_done", 32'(req_done), 32'h1);
        tick();
        quiet();
        #2;
        cmp("mis_rv", 32'(resp_valid), 32'h1);
        cmp("mis_err", 32'(resp_err), 32'h1);
        cmp("mis_rfwe", 32'(rf_we), 32'h0);
        tick();
`ifdef IBEX_LSU_ERR_ADDR_EN
        cmp("mis_eaddr", err_addr, 32'h4002);
`endif

        // bus error on a word load, then an immediate new request
        issue(1'b0, 2'b00, 1'b0, 32'h5000, 32'h0, 1'b1);
        tick();
        quiet();
        data_rvalid = 1'b1;
        data_err    = 1'b1;
        data_rdata  = 32'hDEAD_BEEF;
        #2;
        cmp("berr_err", 32'(resp_err), 32'h1);
        cmp("berr_rfwe", 32'(rf_we), 32'h0);
        cmp("berr_rfwd", rf_wdata, 32'h0);
        tick();
        quiet();
        issue(1'b0, 2'b11, 1'b0, 32'h6000, 32'h0, 1'b1);
        #2;
        cmp("b2b_done", 32'(req_done), 32'h1);
        cmp("b2b_req", 32'(data_req), 32'h1);
        tick();
        quiet();
        data_rvalid = 1'b1;
        data_rdata  = 32'h1234_5678;
        #2;
        cmp("b2b_rfwd", rf_wdata, 32'h1234_5678);
`ifdef IBEX_LSU_ERR_ADDR_EN
        cmp("berr_eaddr", err_addr, 32'h5000);
`endif
        tick();
        quiet();

        // signed half, unsigned byte, stray rvalid and gnt in IDLE
        issue(1'b0, 2'b01, 1'b1, 32'h7002, 32'h0, 1'b1);
        tick();
        quiet();
        data_rvalid = 1'b1;
        data_rdata  = 32'h8001_0000;
        #2;
        cmp("lhs_rfwd", rf_wdata, 32'hFFFF_8001);
        tick();
        quiet();
        issue(1'b0, 2'b10, 1'b0, 32'h7101, 32'h0, 1'b1);
        tick();
        quiet();
        data_rvalid = 1'b1;
        data_rdata  = 32'h0000_F700;
        #2;
        cmp("lbu_rfwd", rf_wdata, 32'h0000_00F7);
        tick();
        quiet();
        data_rvalid = 1'b1;
        data_gnt    = 1'b1;
        #2;
        cmp("stray_rv", 32'(resp_valid), 32'h0);
        cmp("stray_busy", 32'(busy), 32'h0);
        tick();
        quiet();

        // reset while waiting for rvalid
        issue(1'b0, 2'b00, 1'b0, 32'h8000, 32'h0, 1'b1);
        tick();
        quiet();
        #2;
        cmp("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        cmp("rst_mid_busy", 32'(busy), 32'h0);
        cmp("rst_mid_req", 32'(data_req), 32'h0);
        cmp("rst_mid_rv", 32'(resp_valid), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        data_rvalid = 1'b1;
        data_rdata  = 32'hFFFF_FFFF;
        #2;
        cmp("post_rst_rv", 32'(resp_valid), 32'h0);
        cmp("post_rst_rfwe", 32'(rf_we), 32'h0);
        tick();
        quiet();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_lsu_resp_unit.md
Name: ibex_lsu_resp_unit

Overview:
- Data-side load/store unit producing the LSU response stream that the writeback stage consumes: `lsu_resp_valid`, `lsu_resp_err`, `rf_we_lsu` and `rf_wdata_lsu`.
- Accepts one load/store request from ID/EX and drives the data bus (req/gnt/rvalid protocol).
- Formats load data with byte/half extraction and sign/zero extension, and reports bus or misalignment errors.
- Allows a single outstanding transaction.

Parameters:
- None. Fixed 32-bit address and data.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- lsu_req_i  in  1  ID/EX requests a load/store this cycle
- lsu_we_i  in  1  1=store, 0=load
- lsu_type_i  in  2  00=word, 01=half, 10=byte, 11=treated as word
- lsu_sign_ext_i  in  1  sign-extend load data
- lsu_addr_i  in  32  byte address
- lsu_wdata_i  in  32  store data, LSB-aligned
- lsu_req_done_o  out  1  request accepted this cycle; ID/EX may retire it to WB
- busy_o  out  1  FSM not IDLE
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  store data shifted to byte lane
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus error, qualified by rvalid
- data_rdata_i  in  32  bus read data
- lsu_resp_valid_o  out  1  one-cycle response pulse
- lsu_resp_err_o  out  1  response is an error; valid only with lsu_resp_valid_o
- rf_we_lsu_o  out  1  load data write to RF
- rf_wdata_lsu_o  out  32  formatted load data

Behaviour:
- Reset: FSM=IDLE. All outputs 0. Captured type, sign, offset and we registers cleared.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID, MIS_ERR.
- Misaligned access: word with addr[1:0]!=0, or half with addr[0]=1.
- IDLE, lsu_req_i=1, aligned:
  - data_req_o=1 combinationally in the same cycle.
  - data_gnt_i=1 → lsu_req_done_o=1, go to WAIT_RVALID.
  - data_gnt_i=0 → go to WAIT_GNT. Address, we, be and wdata are captured and held stable until grant.
- IDLE, lsu_req_i=1, misaligned:
  - No bus request. lsu_req_done_o=1, go to MIS_ERR.
- WAIT_GNT: data_req_o=1 with captured fields. On gnt: lsu_req_done_o=1, go to WAIT_RVALID.
- WAIT_RVALID:
  - data_req_o=0; new requests are not accepted (lsu_req_done_o=0).
  - On data_rvalid_i: lsu_resp_valid_o=1, lsu_resp_err_o=data_err_i, rf_we_lsu_o = ~we & ~data_err_i, go to IDLE.
- MIS_ERR: lsu_resp_valid_o=1, lsu_resp_err_o=1, rf_we_lsu_o=0; go to IDLE next cycle.
- All response outputs are combinational from FSM state and bus inputs, so data latency is 0 cycles after rvalid.
- Back-to-back: a new request may be presented in the cycle after the response; the earliest acceptance is the first IDLE cycle.
- Byte enables from offset o=addr[1:0]:
  - byte: 1<<o
  - half: 2'b11<<o
  - word: 4'hF
- data_wdata_o = lsu_wdata_i << (8*o). Upper bits are discarded; lower lanes are zero-filled.
- Load formatting: shift data_rdata_i right by 8*captured offset, then:
  - byte: bit 7 extended per captured sign flag
  - half: bit 15 extended per captured sign flag
  - word: unchanged
- rf_wdata_lsu_o = 0 when rf_we_lsu_o=0.
- Stores: rvalid still produces lsu_resp_valid_o=1 so WB can retire the store; rf_we_lsu_o=0.
- data_rvalid_i outside WAIT_RVALID is ignored.
- data_gnt_i outside a request is ignored.
- Reset mid-operation: return to IDLE immediately; any in-flight bus response is dropped. The system resets the bus together with the LSU.

Optional Feature:
- Macro: IBEX_LSU_ERR_ADDR_EN.
- When defined: adds output lsu_err_addr_o [31:0].
  - Loaded with the full byte address of the access whenever lsu_resp_err_o=1 with lsu_resp_valid_o=1.
  - Holds that value until the next error response. Reset 0.
- When not defined: the port and its register are absent. The request address is captured only for the bus.

Test Plan:
- Load byte at 0x1003, gnt same cycle, rvalid 2 cycles later with rdata=0x80FF_0000, sign=1 → data_be_o=4'b1000, rf_wdata_lsu_o=0xFFFF_FF80, rf_we_lsu_o=1, resp_err=0.
- Load half unsigned at 0x2002, gnt delayed 3 cycles → data_req_o held with address 0x2000 and be 4'b1100 for all 4 cycles. With rdata=0xBEEF_1234 → rf_wdata_lsu_o=0x0000_BEEF.
- Store byte 0xA5 at 0x3001 → data_wdata_o=0x0000_A500, be=4'b0010, we=1. On rvalid: resp_valid=1, rf_we_lsu_o=0.
- Load word at 0x4002 → no data_req_o, lsu_req_done_o=1. Next cycle resp_valid=1, resp_err=1, rf_we=0. With IBEX_LSU_ERR_ADDR_EN: lsu_err_addr_o=0x4002.
- Load word with rvalid and data_err_i=1 → resp_err=1, rf_we_lsu_o=0, rf_wdata_lsu_o=0. A new request on the following cycle is accepted.
- rst_i asserted in WAIT_RVALID → all outputs 0 and busy_o=0 immediately. A later stray rvalid produces no response.
